// File: rtl/fft_unload.sv
// fft_unload: streams 2048-point FFT results out of the four bank RAMs
// as natural-order (or storage-order) bins on a valid/ready interface.

module fft_unload #(
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 2,
  parameter int REORDER = 1
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iBANK_SEL,
  output logic              oRD_EN,
  output logic [8:0]        oADDR_RD,
  output logic [1:0]        oBANK,
  output logic              oSEL_B,
  input  logic [2*DATA_W-1:0] iRD_DATA_0,
  input  logic [2*DATA_W-1:0] iRD_DATA_1,
  input  logic [2*DATA_W-1:0] iRD_DATA_2,
  input  logic [2*DATA_W-1:0] iRD_DATA_3,
  output logic [DATA_W-1:0] oDATA_RE,
  output logic [DATA_W-1:0] oDATA_IM,
  output logic [10:0]       oINDEX,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oSOP,
  output logic              oEOP,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LW    = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic        vld;
    logic [1:0]  bank;
    logic [10:0] idx;
  } tag_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [10:0]       idx;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } beat_t;

  state_t              state;
  logic [10:0]         n;
  logic [10:0]         m;
  logic [10:0]         rd_idx;
  tag_t                pipe [RD_LAT];
  tag_t                ret;
  beat_t               slot [DEPTH];
  beat_t               nb;
  logic [CW-1:0]       count;
  logic [LW-1:0]       inflight;
  logic [LW-1:0]       level;
  logic [LW-1:0]       limit;
  logic [2*DATA_W-1:0] rdw;
  logic                pop;
  logic                push;
  logic                issue;

  always_comb begin
    if (REORDER != 0)
      m = {n[1:0], n[3:2], n[5:4], n[7:6], n[9:8], n[10]};
    else
      m = n;
  end

  always_comb begin
    inflight = LW'(oRD_EN);
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + LW'(pipe[i].vld);
  end

  // a beat leaving this cycle frees its slot for the read issued now
  assign ret   = pipe[RD_LAT-1];
  assign pop   = oVALID & iREADY;
  assign push  = ret.vld;
  assign level = LW'(count) + inflight;
  assign limit = LW'(DEPTH) + LW'(pop);
  assign issue = (state == RUN) && (level < limit);

  always_comb begin
    rdw = '0;
    unique case (ret.bank)
      2'd0: rdw = iRD_DATA_0;
      2'd1: rdw = iRD_DATA_1;
      2'd2: rdw = iRD_DATA_2;
      2'd3: rdw = iRD_DATA_3;
    endcase
  end

  assign nb = {ret.idx == 11'd0, ret.idx == 11'h7ff,
               ret.idx, rdw};

  assign oVALID   = (count != '0);
  assign oDATA_RE = slot[0].re;
  assign oDATA_IM = slot[0].im;
  assign oINDEX   = slot[0].idx;
  assign oSOP     = slot[0].sop;
  assign oEOP     = slot[0].eop;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state    <= IDLE;
      n        <= '0;
      rd_idx   <= '0;
      oRD_EN   <= 1'b0;
      oADDR_RD <= '0;
      oBANK    <= '0;
      oSEL_B   <= 1'b0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
      count    <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      for (int i = 0; i < DEPTH; i++)  slot[i] <= '0;
    end else begin
      oDONE  <= 1'b0;
      oRD_EN <= issue;
      if (issue) begin
        oADDR_RD <= m[8:0];
        oBANK    <= m[10:9];
        rd_idx   <= n;
        n        <= n + 11'd1;
      end
      pipe[0] <= '{vld: oRD_EN, bank: oBANK, idx: rd_idx};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      // slot[0] is the output register; pops shift the queue down
      for (int i = 0; i < DEPTH - 1; i++)
        if (pop) slot[i] <= slot[i+1];
      if (push) slot[count - CW'(pop)] <= nb;
      count <= count + CW'(push) - CW'(pop);
      unique case (state)
        IDLE: if (iSTART) begin
          state  <= RUN;
          oSEL_B <= iBANK_SEL;
          oBUSY  <= 1'b1;
          n      <= '0;
        end
        RUN: if (issue && n == 11'h7ff) state <= DRAIN;
        DRAIN: if (inflight == '0 && count == CW'(1) && pop) begin
          state <= IDLE;
          oBUSY <= 1'b0;
          oDONE <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_unload.sv
// tb_fft_unload: three fft_unload instances (linear, reordered, RD_LAT=4)
// fed from a RAM model; beats checked against an arithmetic reorder model.

module tb_fft_unload;

  typedef struct {
    int          ph;
    int          g;
    int          n;
    logic [15:0] re;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        bsel;
  logic        rdy   [3];
  logic        rd_en [3];
  logic [8:0]  addr  [3];
  logic [1:0]  bank  [3];
  logic        sel_b [3];
  logic [15:0] dre   [3];
  logic [15:0] dim   [3];
  logic [10:0] idx   [3];
  logic        vld   [3];
  logic        sop   [3];
  logic        eop   [3];
  logic        busy  [3];
  logic        done  [3];

  int          applied = 0;
  int          errs = 0;
  int          cyc = 0;
  bit          exp_sel;
  int          beats [3];
  int          reads [3];
  int          dones [3];
  int          first_hs [3];
  int          last_hs [3];
  logic        stalled [3];
  logic [45:0] held [3];
  logic [15:0] cap [3][2048];
  vec_t        tbl [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] ramw(logic s, logic [1:0] b,
                                       logic [8:0] a);
    logic [15:0] r;
    r = {s, 4'b0, b, a};
    return {r, ~r};
  endfunction

  function automatic int lat(int g);
    return (g == 2) ? 4 : 2;
  endfunction

  function automatic int ro(int g);
    return (g == 0) ? 0 : 1;
  endfunction

  function automatic logic [10:0] mdl(int n, int r);
    int m;
    if (r == 0) m = n;
    else m = (n & 3) * 512 + ((n >> 2) & 3) * 128
           + ((n >> 4) & 3) * 32 + ((n >> 6) & 3) * 8
           + ((n >> 8) & 3) * 2 + ((n >> 10) & 1);
    return 11'(m);
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 2) ? 4 : 2;
      localparam int RO  = (g == 0) ? 0 : 1;
      logic [9:0]  ap [LAT];
      logic [31:0] rd [4];

      always @(posedge clk) begin
        ap[0] <= {sel_b[g], addr[g]};
        for (int k = 1; k < LAT; k++) ap[k] <= ap[k-1];
      end

      always_comb
        for (int b = 0; b < 4; b++)
          rd[b] = ramw(ap[LAT-1][9], 2'(b), ap[LAT-1][8:0]);

      fft_unload #(
        .DATA_W(16), .RD_LAT(LAT), .REORDER(RO)
      ) u_dut (
        .iCLK(clk), .iRESET(rst_n),
        .iSTART(start), .iBANK_SEL(bsel),
        .oRD_EN(rd_en[g]), .oADDR_RD(addr[g]),
        .oBANK(bank[g]), .oSEL_B(sel_b[g]),
        .iRD_DATA_0(rd[0]), .iRD_DATA_1(rd[1]),
        .iRD_DATA_2(rd[2]), .iRD_DATA_3(rd[3]),
        .oDATA_RE(dre[g]), .oDATA_IM(dim[g]),
        .oINDEX(idx[g]), .oVALID(vld[g]),
        .iREADY(rdy[g]), .oSOP(sop[g]), .oEOP(eop[g]),
        .oBUSY(busy[g]), .oDONE(done[g])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic mon();
    for (int g = 0; g < 3; g++) begin
      logic [45:0] cur;
      logic [15:0] er;
      cur = {idx[g], dre[g], dim[g], sop[g], eop[g], sel_b[g]};
      if (!rst_n) begin
        stalled[g] = 1'b0;
        continue;
      end
      if (start && !busy[g]) begin
        beats[g] = 0;
        reads[g] = 0;
        dones[g] = 0;
        first_hs[g] = -1;
      end
      reads[g] += int'(rd_en[g]);
      if (busy[g])
        chk("credit", 64'((reads[g] - beats[g]) <= lat(g) + 2), 1);
      if (vld[g] && stalled[g]) chk("stall_hold", cur, held[g]);
      if (vld[g] && rdy[g]) begin
        er = {exp_sel, 4'b0, mdl(beats[g], ro(g))};
        chk($sformatf("beat%0d_n%0d", g, beats[g]), cur,
            {11'(beats[g]), er, ~er, beats[g] == 0,
             beats[g] == 2047, exp_sel});
        if (beats[g] < 2048) cap[g][beats[g]] = dre[g];
        if (beats[g] == 0) first_hs[g] = cyc;
        last_hs[g] = cyc;
        beats[g]++;
      end
      if (done[g]) begin
        dones[g]++;
        chk("done_timing", last_hs[g], cyc - 1);
      end
      stalled[g] = vld[g] && !rdy[g];
      held[g] = cur;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_reset_outs(input string nm);
    for (int g = 0; g < 3; g++)
      chk($sformatf("%s%0d", nm, g),
          {rd_en[g], addr[g], bank[g], sel_b[g], dre[g], dim[g],
           idx[g], vld[g], sop[g], eop[g], busy[g], done[g]}, 0);
  endtask

  task automatic run(input int limit, input bit rnd, input int restart);
    int t;
    t = 0;
    do begin
      tick();
      t++;
      start = 1'b0;
      if (rnd)
        for (int i = 0; i < 3; i++) rdy[i] = ($urandom_range(0, 99) < 30);
      if (t == restart) begin
        bsel  = 1'b0;
        start = 1'b1;
      end
    end while ((busy[0] || busy[1] || busy[2]) && t < limit);
    chk("timeout", 64'(t < limit), 1);
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
  endtask

  task automatic check_pkt(input bit bub);
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("beats%0d", g), beats[g], 2048);
      chk($sformatf("done_count%0d", g), dones[g], 1);
      chk($sformatf("busy_low%0d", g), busy[g], 0);
      if (bub)
        chk($sformatf("no_bubbles%0d", g),
            last_hs[g] - first_hs[g], 2047);
    end
  endtask

  task automatic check_tbl(input int ph);
    foreach (tbl[i])
      if (tbl[i].ph == ph)
        chk($sformatf("vec_g%0d_n%0d", tbl[i].g, tbl[i].n),
            cap[tbl[i].g][tbl[i].n], tbl[i].re);
  endtask

  initial begin
    int fr [3];
    int fv [3];
    int t;
    tbl.push_back('{0, 0, 0, 16'd0});
    tbl.push_back('{0, 0, 1, 16'd1});
    tbl.push_back('{0, 0, 700, 16'd700});
    tbl.push_back('{0, 0, 2047, 16'd2047});
    tbl.push_back('{0, 1, 1, 16'd512});
    tbl.push_back('{0, 1, 2, 16'd1024});
    tbl.push_back('{0, 1, 3, 16'd1536});
    tbl.push_back('{0, 1, 4, 16'd128});
    tbl.push_back('{0, 1, 5, 16'd640});
    tbl.push_back('{0, 1, 1024, 16'd1});
    tbl.push_back('{0, 1, 2047, 16'd2047});
    tbl.push_back('{0, 2, 1, 16'd512});
    tbl.push_back('{0, 2, 6, 16'd1152});
    tbl.push_back('{1, 0, 5, 16'h8005});
    tbl.push_back('{1, 1, 1, 16'h8200});
    tbl.push_back('{1, 2, 1024, 16'h8001});
    tbl.push_back('{2, 0, 0, 16'd0});
    tbl.push_back('{2, 0, 2047, 16'd2047});
    tbl.push_back('{2, 1, 16, 16'd32});

    rst_n = 1'b0;
    start = 1'b0;
    bsel = 1'b0;
    exp_sel = 1'b0;
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
    repeat (3) tick();
    check_reset_outs("reset_state");
    rst_n = 1'b1;
    tick();

    // linear and reordered packets, RD_LAT=4 instance held off 10 clocks
    rdy[2] = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      fr[g] = -1;
      fv[g] = -1;
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        if (rd_en[g] && fr[g] < 0) fr[g] = k;
        if (vld[g] && fv[g] < 0) fv[g] = k;
      end
      if (k == 9) begin
        chk("lat4_reads", reads[2], 6);
        chk("lat4_rd_idle", rd_en[2], 0);
      end
      if (k == 10) rdy[2] = 1'b1;
    end
    chk("first_rd0", fr[0], 1);
    chk("first_valid0", fv[0], 4);
    chk("first_valid1", fv[1], 4);
    chk("first_rd2", fr[2], 1);
    chk("first_valid2", fv[2], 6);
    run(8000, 1'b0, -1);
    check_pkt(1'b1);
    check_tbl(0);

    // random stalls, bank set B, ignored restart mid-packet
    exp_sel = 1'b1;
    bsel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(40000, 1'b1, 100);
    check_pkt(1'b0);
    check_tbl(1);

    // async reset mid-packet, then a clean packet
    exp_sel = 1'b0;
    bsel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (beats[0] < 700 && t < 3000) begin
      tick();
      t++;
    end
    chk("reach_700", 64'(beats[0] >= 700), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("async_reset");
    repeat (3) tick();
    for (int g = 0; g < 3; g++)
      chk($sformatf("no_done_abort%0d", g), dones[g], 0);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run(8000, 1'b0, -1);
    check_pkt(1'b1);
    check_tbl(2);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule
